// File: rtl/branch_compare_unit.sv
// -----------------------------------------------------------------------------
// branch_compare_unit
//
// Pipelined RISC-V branch comparator for the EX stage. Computes the Eq, Lt
// (signed) and Ltu (unsigned) relations of two operands, resolves the branch
// decision from funct3, and delivers the result LATENCY register stages later
// together with a pass-through tag. The pipeline obeys Stall and Flush from the
// hazard unit. Two saturating counters record consumed compares and consumed
// taken branches.
//
// Parameters:
//   WIDTH   - operand width in bits (>= 2)
//   LATENCY - number of register stages (1..4)
//   TAG_W   - width of the pass-through tag
//   CNT_W   - width of each performance counter
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   Valid_In   - operands/funct3/tag are valid this cycle
//   Data0      - rs1 operand
//   Data1      - rs2 operand
//   Funct3     - branch funct3
//   Tag_In     - tag accompanying the compare
//   Stall      - freeze every stage, input not captured
//   Flush      - invalidate every in-flight compare, input dropped
//   Valid_Out  - output stage holds a valid result
//   Eq/Lt/Ltu  - registered compare flags
//   Taken      - registered branch decision (0 when Valid_Out=0)
//   Illegal    - funct3 was 010/011 (0 when Valid_Out=0)
//   Tag_Out    - tag of the result
//   Cnt_Cmp    - saturating count of consumed compares
//   Cnt_Taken  - saturating count of consumed taken branches
// -----------------------------------------------------------------------------
module branch_compare_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Valid_In,
    input  logic [WIDTH-1:0] Data0,
    input  logic [WIDTH-1:0] Data1,
    input  logic [2:0]       Funct3,
    input  logic [TAG_W-1:0] Tag_In,
    input  logic             Stall,
    input  logic             Flush,
    output logic             Valid_Out,
    output logic             Eq,
    output logic             Lt,
    output logic             Ltu,
    output logic             Taken,
    output logic             Illegal,
    output logic [TAG_W-1:0] Tag_Out,
    output logic [CNT_W-1:0] Cnt_Cmp,
    output logic [CNT_W-1:0] Cnt_Taken
);

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_RSV2 = 3'b010,
        F3_RSV3 = 3'b011,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    // ------------------------------------------------------------------------
    // Stage-1 input: combinational compare and branch resolution
    // ------------------------------------------------------------------------
    funct3_e w_f3;
    logic    w_eq;
    logic    w_lt;
    logic    w_ltu;
    logic    w_taken;
    logic    w_illegal;

    assign w_f3  = funct3_e'(Funct3);
    assign w_eq  = (Data0 == Data1);
    assign w_ltu = (Data0 < Data1);
    assign w_lt  = ($signed(Data0) < $signed(Data1));

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (w_f3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = ~w_eq;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = ~w_lt;
            F3_BLTU: w_taken = w_ltu;
            F3_BGEU: w_taken = ~w_ltu;
            F3_RSV2: w_illegal = 1'b1;
            F3_RSV3: w_illegal = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline stages, index 0 is stage 1, index LATENCY-1 drives the outputs
    // ------------------------------------------------------------------------
    logic             r_valid   [LATENCY];
    logic             r_eq      [LATENCY];
    logic             r_lt      [LATENCY];
    logic             r_ltu     [LATENCY];
    logic             r_taken   [LATENCY];
    logic             r_illegal [LATENCY];
    logic [TAG_W-1:0] r_tag     [LATENCY];

    logic [CNT_W-1:0] r_cnt_cmp;
    logic [CNT_W-1:0] r_cnt_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                r_valid[k]   <= 1'b0;
                r_eq[k]      <= 1'b0;
                r_lt[k]      <= 1'b0;
                r_ltu[k]     <= 1'b0;
                r_taken[k]   <= 1'b0;
                r_illegal[k] <= 1'b0;
                r_tag[k]     <= '0;
            end
            r_cnt_cmp   <= '0;
            r_cnt_taken <= '0;
        end else if (Flush) begin
            // Taken/Illegal are cleared with valid so an invalid output never
            // presents a decision; the remaining data fields may stay stale.
            for (int unsigned k = 0; k < LATENCY; k++) begin
                r_valid[k]   <= 1'b0;
                r_taken[k]   <= 1'b0;
                r_illegal[k] <= 1'b0;
            end
        end else if (!Stall) begin
            // Consume the result currently on the outputs.
            if (r_valid[LATENCY-1]) begin
                if (r_cnt_cmp != '1) begin
                    r_cnt_cmp <= r_cnt_cmp + CNT_W'(1);
                end
                if (r_taken[LATENCY-1] && (r_cnt_taken != '1)) begin
                    r_cnt_taken <= r_cnt_taken + CNT_W'(1);
                end
            end

            // Bubbles carry Taken/Illegal low so they stay 0 with valid low.
            r_valid[0]   <= Valid_In;
            r_eq[0]      <= w_eq;
            r_lt[0]      <= w_lt;
            r_ltu[0]     <= w_ltu;
            r_taken[0]   <= Valid_In & w_taken;
            r_illegal[0] <= Valid_In & w_illegal;
            r_tag[0]     <= Tag_In;

            for (int unsigned k = 1; k < LATENCY; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_eq[k]      <= r_eq[k-1];
                r_lt[k]      <= r_lt[k-1];
                r_ltu[k]     <= r_ltu[k-1];
                r_taken[k]   <= r_taken[k-1];
                r_illegal[k] <= r_illegal[k-1];
                r_tag[k]     <= r_tag[k-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from the last stage
    // ------------------------------------------------------------------------
    assign Valid_Out = r_valid[LATENCY-1];
    assign Eq        = r_eq[LATENCY-1];
    assign Lt        = r_lt[LATENCY-1];
    assign Ltu       = r_ltu[LATENCY-1];
    assign Taken     = r_taken[LATENCY-1];
    assign Illegal   = r_illegal[LATENCY-1];
    assign Tag_Out   = r_tag[LATENCY-1];
    assign Cnt_Cmp   = r_cnt_cmp;
    assign Cnt_Taken = r_cnt_taken;

endmodule

// File: doc/branch_compare_unit.md
# branch_compare_unit

Pipelined, parametrised RISC-V branch comparator for the EX stage; successor to the plain N-bit equality comparator. Takes two WIDTH-bit operands plus the branch funct3, and produces registered Eq/Lt/Ltu flags and a Taken decision after LATENCY cycles. Results carry a tag, and the pipeline honours stall and flush from the hazard unit. Two saturating counters record consumed compares and taken branches for performance monitoring.

## Interface
- WIDTH, 32, operand width in bits (≥ 2)
- LATENCY, 1, pipeline depth in register stages (1..4)
- TAG_W, 5, width of the pass-through tag (e.g. rd or ROB index)
- CNT_W, 16, width of each performance counter
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- Valid_In  input  1  operands and funct3 are valid this cycle
- Data0  input  WIDTH  rs1 operand
- Data1  input  WIDTH  rs2 operand
- Funct3  input  3  branch funct3
- Tag_In  input  TAG_W  tag accompanying the compare
- Stall  input  1  freeze the whole pipeline
- Flush  input  1  kill every in-flight compare
- Valid_Out  output  1  output stage holds a valid result
- Eq  output  1  Data0 == Data1
- Lt  output  1  signed Data0 < Data1
- Ltu  output  1  unsigned Data0 < Data1
- Taken  output  1  branch decision
- Illegal  output  1  Funct3 is 010 or 011
- Tag_Out  output  TAG_W  tag of the result
- Cnt_Cmp  output  CNT_W  consumed-compare count
- Cnt_Taken  output  CNT_W  consumed taken-branch count

## Operation
- Flag computation, combinational at the stage-1 input:
  - Eq = (Data0 == Data1).
  - Ltu is the unsigned compare.
  - Lt is the signed two's-complement compare, with the MSB as the sign bit.
- Taken by Funct3:
  - 000 → Eq; 001 → !Eq
  - 100 → Lt; 101 → !Lt
  - 110 → Ltu; 111 → !Ltu
  - 010 or 011 → Taken=0, Illegal=1
- Pipeline: LATENCY stages. Each stage holds {valid, Eq, Lt, Ltu, Taken, Illegal, tag}. The outputs are the last stage.
- Per-cycle update priority: rst > Flush > Stall > normal advance.
  - rst: all valid bits = 0, all flag and tag registers = 0, both counters = 0.
  - Flush (rst=0): all valid bits = 0 next cycle. Data registers may keep stale values. The input this cycle is dropped, and Stall is ignored.
  - Stall (rst=0, Flush=0): every stage, including the output stage, holds its value. The input is not captured.
  - Normal: stage 1 captures Valid_In and the computed fields; stage k captures stage k-1.
- A bubble (Valid_In=0) propagates with valid=0. Data fields behind a bubble are don't-care, but Taken and Illegal must be 0 whenever Valid_Out=0.
- Counters, evaluated on each edge where Valid_Out=1, Stall=0, Flush=0 and rst=0:
  - Cnt_Cmp increments by 1.
  - Cnt_Taken increments by 1 if Taken=1.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - Illegal results count in Cnt_Cmp only.
- Counters are cleared only by rst.

## Timing
- Reset values: Valid_Out=0, Eq=0, Lt=0, Ltu=0, Taken=0, Illegal=0, Tag_Out=0, Cnt_Cmp=0, Cnt_Taken=0.
- Latency: an input accepted at edge N (Valid_In=1, Stall=0, Flush=0) is visible on the outputs after edge N+LATENCY−1 and held until the next edge.
  - With LATENCY=1, outputs change right after the capturing edge.
  - Each stalled cycle adds exactly one cycle of delay.
- Throughput: one compare per cycle when not stalled; back-to-back results appear on consecutive cycles.
- Flush asserted with Stall in the same cycle: flush wins. The next cycle shows Valid_Out=0, and the counters do not increment.
- rst asserted mid-pipeline clears everything on that edge; no partial results emerge.
- No combinational path from any input to any output.

## Test plan
- Reset with LATENCY=2: hold rst for 2 cycles → all outputs 0; Valid_Out stays 0 for 2 cycles after release with Valid_In=0.
- Equality and signedness, WIDTH=32, LATENCY=1:
  - 0x01234567 vs 0x01234567, funct3 000 → Eq=1, Taken=1.
  - 0xFFFFFFFF vs 0x00000001, funct3 100 → Lt=1, Ltu=0, Taken=1.
  - Same operands, funct3 110 → Taken=0.
  - Same operands, funct3 111 → Taken=1.
- Funct3 coverage with LATENCY=3: stream 0x01234567/0x01234568 for all 8 funct3 values back-to-back → 8 consecutive results starting 3 cycles later, in order.
  - Taken = 0,1,0,0,1,0,1,0 for funct3 000..111.
  - Illegal=1 only for 010 and 011.
  - Tags match their inputs.
- Stall and flush with LATENCY=2:
  - Issue tags 1,2,3 on consecutive cycles, stalling 2 cycles after the first issue → Valid_Out/Tag_Out hold during the stall, then tags 2 and 3 follow.
  - Flush while tags 4 and 5 are in flight → neither emerges, and the counters are unchanged.
- Counter saturation with CNT_W=3: 10 taken compares → Cnt_Cmp=7 and Cnt_Taken=7, holding; 2 not-taken compares after that → both remain 7.
